// File: rtl/corefifo_wr_ptr_gen_if.sv
// Write-port bundle between the FIFO write logic (master) and the write pointer generator (slave).
// It also carries the gray read pointer arriving from the read clock domain.
interface corefifo_wr_ptr_gen_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 we;
    logic [ADDRWIDTH:0]   rd_ptr_gray_in;
    logic                 wen_ram;
    logic [ADDRWIDTH-1:0] waddr;
    logic [ADDRWIDTH:0]   wr_ptr_bin;
    logic [ADDRWIDTH:0]   wr_ptr_gray;
    logic [ADDRWIDTH:0]   wr_count;
    logic                 full;
    logic                 afull;
    logic                 overflow;

    modport master (
        output we, rd_ptr_gray_in,
        input  wen_ram, waddr, wr_ptr_bin, wr_ptr_gray, wr_count, full, afull, overflow
    );

    modport slave (
        input  we, rd_ptr_gray_in,
        output wen_ram, waddr, wr_ptr_bin, wr_ptr_gray, wr_count, full, afull, overflow
    );
endinterface

// File: rtl/corefifo_wr_ptr_gen.sv
// Write-side pointer and flag generator for the dual-clock FIFO: binary/gray write pointer,
// read-pointer synchronizer, and registered occupancy, full, almost-full and overflow flags.
module corefifo_wr_ptr_gen #(
    parameter int ADDRWIDTH    = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    corefifo_wr_ptr_gen_if.slave    bus
);
    localparam int PW    = ADDRWIDTH + 1;
    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [PW-1:0] wptr_bin;
    logic [PW-1:0] wptr_gray;
    logic [PW-1:0] count;
    logic          full_q;
    logic          afull_q;
    logic          ovf_q;
    logic [PW-1:0] rd_sync [SYNC_STAGES];

    logic          accept;
    logic [PW-1:0] next_bin;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] occupancy;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

    // Occupancy is computed against the next-state write pointer so that full
    // rises on the very edge that accepts the filling write.
    always_comb begin
        accept    = bus.we & ~full_q;
        next_bin  = wptr_bin + {{ADDRWIDTH{1'b0}}, accept};
        rd_bin    = gray2bin(rd_sync[SYNC_STAGES-1]);
        occupancy = next_bin - rd_bin;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= '0;
            end
        end else begin
            rd_sync[0] <= bus.rd_ptr_gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= rd_sync[i-1];
            end
        end
    end

    // The stale synchronized read pointer can only overstate occupancy, never understate it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_bin  <= '0;
            wptr_gray <= '0;
            count     <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wptr_bin  <= next_bin;
            wptr_gray <= bin2gray(next_bin);
            count     <= occupancy;
            full_q    <= (occupancy == PW'(DEPTH));
            afull_q   <= (occupancy >= PW'(AFULL_THRESH));
            ovf_q     <= bus.we & full_q;
        end
    end

    // The RAM is never written while the block is held in reset.
    assign bus.wen_ram     = accept & rstn;
    assign bus.waddr       = wptr_bin[ADDRWIDTH-1:0];
    assign bus.wr_ptr_bin  = wptr_bin;
    assign bus.wr_ptr_gray = wptr_gray;
    assign bus.wr_count    = count;
    assign bus.full        = full_q;
    assign bus.afull       = afull_q;
    assign bus.overflow    = ovf_q;
endmodule
